// File: rtl/cplx_dot_pkg.sv
// Shared types and helpers for the streaming complex dot-product engine.
// Holds the FSM state encoding and the accumulator width rule.
package cplx_dot_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    DONE  = ST_DONE
  } state_t;

  // Wide enough for LEN worst-case products, including -2^(WIDTH-1) squared terms.
  function automatic int acc_width(input int width, input int len);
    return 2 * width + 1 + $clog2(len);
  endfunction

endpackage

// File: rtl/cplx_dot_engine_mult.sv
// One-stage registered signed complex multiplier with optional conjugation of b.
// Output components are 2*WIDTH+1 bits so the sum of two products never wraps.
module cplx_mult #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      conj,
  input  logic signed [WIDTH-1:0]   aReal,
  input  logic signed [WIDTH-1:0]   aImag,
  input  logic signed [WIDTH-1:0]   bReal,
  input  logic signed [WIDTH-1:0]   bImag,
  output logic signed [2*WIDTH:0]   pReal,
  output logic signed [2*WIDTH:0]   pImag
);

  localparam int PW = 2 * WIDTH + 1;

  logic signed [2*WIDTH-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0]      sumReal, sumImag;

  assign rr = aReal * bReal;
  assign ii = aImag * bImag;
  assign ri = aReal * bImag;
  assign ir = aImag * bReal;

  // Conjugating b flips the sign of every term that involves bImag.
  always_comb begin
    sumReal = PW'(rr) - PW'(ii);
    sumImag = PW'(ri) + PW'(ir);
    if (conj) begin
      sumReal = PW'(rr) + PW'(ii);
      sumImag = PW'(ir) - PW'(ri);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pReal <= '0;
      pImag <= '0;
    end else if (en) begin
      pReal <= sumReal;
      pImag <= sumImag;
    end
  end

endmodule

// File: rtl/cplx_dot_engine.sv
// Streaming complex dot-product engine: FSM, element counter and accumulator
// around a single registered complex multiplier.
module cplx_dot_engine
  import cplx_dot_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN   = 4,
  parameter int ACCW  = acc_width(WIDTH, LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     conj,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  aReal,
  input  logic signed [WIDTH-1:0]  aImag,
  input  logic signed [WIDTH-1:0]  bReal,
  input  logic signed [WIDTH-1:0]  bImag,
  output logic                     busy,
  output logic                     done,
  output logic signed [ACCW-1:0]   resReal,
  output logic signed [ACCW-1:0]   resImag
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  state_t state, nextState;

  logic [CW-1:0]           count;
  logic                    conjLat;
  logic                    prodValid;
  logic                    handshake;
  logic                    startOk;
  logic                    lastPair;
  logic signed [2*WIDTH:0] pReal, pImag;
  logic signed [ACCW-1:0]  accReal, accImag;

  assign startOk   = start && (state == IDLE || state == DONE);
  assign handshake = in_valid && (state == RUN);
  assign lastPair  = (count == CW'(LEN - 1));
  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == FLUSH);

  cplx_mult #(.WIDTH(WIDTH)) uMult (
    .clk   (clk),
    .rst   (rst),
    .en    (handshake),
    .conj  (conjLat),
    .aReal (aReal),
    .aImag (aImag),
    .bReal (bReal),
    .bImag (bImag),
    .pReal (pReal),
    .pImag (pImag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // FLUSH waits for the last registered product to drain into the accumulator.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: if (startOk) nextState = RUN;
      RUN:        if (handshake && lastPair) nextState = FLUSH;
      FLUSH:      if (!prodValid) nextState = DONE;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      conjLat   <= 1'b0;
      prodValid <= 1'b0;
      accReal   <= '0;
      accImag   <= '0;
      done      <= 1'b0;
      resReal   <= '0;
      resImag   <= '0;
    end else begin
      done      <= 1'b0;
      prodValid <= handshake;
      if (startOk) begin
        count   <= '0;
        conjLat <= conj;
        accReal <= '0;
        accImag <= '0;
      end else if (prodValid) begin
        accReal <= accReal + ACCW'(pReal);
        accImag <= accImag + ACCW'(pImag);
      end
      if (handshake && !lastPair) count <= count + CW'(1);
      if (state == FLUSH && !prodValid) begin
        done    <= 1'b1;
        resReal <= accReal;
        resImag <= accImag;
      end
    end
  end

endmodule

// File: doc/cplx_dot_engine.md
# cplx_dot_engine

Parametrised streaming complex dot-product engine for the V2V sorter datapath. After a `start` it accepts `LEN` pairs of signed complex samples over a valid/ready handshake and computes Σ a_k·b_k, or Σ a_k·conj(b_k) in conjugate mode. A single registered complex multiplier feeds a full-precision accumulator. The block generalises the fixed four-sample dot-product unit to arbitrary width and vector length, and adds a conjugate mode, backpressure and a busy indication.

## Interface
- `WIDTH`, 8: bit width of each signed real/imag input component.
- `LEN`, 4: vector length; must be ≥ 1.
- `ACCW`, 2*WIDTH+1+$clog2(LEN): derived result width; not to be overridden.
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new dot product; honoured only in IDLE or DONE.
- `conj` in 1: sampled with an accepted `start`; 1 conjugates every b_k.
- `in_valid` in 1: the current a/b pair is valid.
- `in_ready` out 1: the block accepts a pair this cycle.
- `aReal`, `aImag`, `bReal`, `bImag` in WIDTH: signed two's-complement sample components.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the result is valid.
- `resReal`, `resImag` out ACCW: signed result; held until the next accepted `start`.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE. Reset state is IDLE.
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `resReal`=0, `resImag`=0. Accumulator, element counter and multiplier register are also cleared.
- IDLE or DONE with `start`=1: clear the accumulator and counter, latch `conj`, go to RUN, set `busy`=1.
- RUN: `in_ready`=1. Each cycle with `in_valid`&&`in_ready` is a handshake. On each handshake, increment the counter and load the multiplier.
  - If conj=0: pr = ar·br − ai·bi, pi = ar·bi + ai·br.
  - If conj=1: pr = ar·br + ai·bi, pi = ai·br − ar·bi.
  - When the LEN-th pair is accepted, go to FLUSH. `in_ready` drops starting the next cycle.
- FLUSH: wait until the final product has been added, then go to DONE. Pulse `done` and clear `busy` in the same edge.
- DONE: results are held. `in_ready`=0.
- Arithmetic:
  - Products are 2*WIDTH+1 bits and are sign-extended to ACCW.
  - No saturation and no rounding. ACCW guarantees no overflow, including for −2^(WIDTH−1) inputs.
- Boundary conditions:
  - `start` during RUN or FLUSH: ignored.
  - `in_valid` outside RUN: ignored, no handshake.
  - `start` and `in_valid` in the same IDLE cycle: only `start` takes effect.
  - `in_valid` gaps in RUN: the counter and accumulator hold.
  - LEN=1: RUN lasts exactly one handshake.
  - Counter runs 0..LEN−1 and is never reused without a new `start`.
  - `rst` mid-operation: immediate return to reset values. The partial sum is discarded.

## Timing
- Multiplier stage: product registered on the handshake edge. Accumulator updated on the following edge.
- Final handshake at edge t → accumulator final at t+1 → `done`=1 and results valid for the cycle after edge t+2. Latency from final handshake to `done` is 2 clocks.
- With no gaps: `start` edge s, handshakes s+1..s+LEN, `done` asserted after edge s+LEN+2.
- `resReal`/`resImag` are registered and updated on the same edge that raises `done`.
- A new `start` in the `done` cycle is accepted. `done` falls and `busy` rises on the next edge.

## Structure
- Package `cplx_dot_pkg` holds:
  - the state enum (IDLE/RUN/FLUSH/DONE);
  - the function acc_width(WIDTH, LEN) returning 2*WIDTH+1+clog2(LEN);
  - the state encoding constants.
- Sub-module `cplx_mult`: one-stage registered signed complex multiplier with a `conj` input and enable, async active-high `rst`, output 2*WIDTH+1 bits per component.
- The top level contains the FSM, element counter and accumulator.

## Test plan
- WIDTH=8, LEN=4, conj=0; all a=(1+1j), b=(1−1j); no gaps → `done` 6 cycles after `start`; result 8+0j.
- Same stimulus, conj=1 → result 0+8j.
- Extremes: all a=b=(−128−128j). conj=0 → 0+131072j. conj=1 → 131072+0j. No overflow.
- Backpressure: pairs a=(3−1j), b=(2+5j) (product 11+13j), with `in_valid` low on alternate cycles → result 44+52j. Exactly 4 handshakes, `in_ready` low after the fourth.
- `start` pulsed during RUN plus extra `in_valid` after the LEN-th pair → both ignored; result unchanged; a single `done` pulse.
- `rst` asserted after 2 handshakes → all outputs 0 at once. Next run with a=(2+0j), b=(0+1j) ×4 → 0+8j.
